// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache and the D-cache.
// One request is served at a time: IDLE (arbitrate) -> ACCESS (hold the bus for
// MEM_LATENCY cycles) -> RESP (one-cycle done pulse to the owner) -> IDLE.
// Build option: define MEM_ARB_FIXED_PRIO_EN to give the D-cache absolute
// priority on ties; otherwise ties are resolved round-robin.
module mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_write_en,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_address_output,
    output logic              mem_write_en,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out,
    output logic              busy
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              owner_q, owner_d;      // 1 = D-cache owns the bus
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              grant_d_port;          // 1 = D wins this arbitration
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
    logic              rr_last_q, rr_last_d;  // 1 = D was granted last
`endif

    // Arbitration: pick the winner among the currently raised requests.
    always_comb begin
        grant_d_port = d_req;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
        if (i_req && d_req) begin
            grant_d_port = ~rr_last_q;
        end
`endif
    end

    // Next-state logic: grant in IDLE, count out the latency, pulse done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
        rr_last_d = rr_last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    owner_d = grant_d_port;
                    we_d    = grant_d_port ? d_write_en : i_write_en;
                    addr_d  = grant_d_port ? d_address  : i_address;
                    wdata_d = grant_d_port ? d_wdata    : i_wdata;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
                    rr_last_d = grant_d_port;
`endif
                end
            end
            S_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    // The read word is valid on the last access cycle.
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = mem_data_out;
                        end else begin
                            i_rdata_d = mem_data_out;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
            rr_last_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
            rr_last_q <= rr_last_d;
`endif
        end
    end

    // Outputs: address/data hold their latched values outside ACCESS.
    assign mem_address_output = addr_q;
    assign mem_data_in        = wdata_q;
    assign mem_write_en       = (state_q == S_ACCESS) && we_q;
    assign busy               = (state_q != S_IDLE);
    assign i_done             = (state_q == S_RESP) && !owner_q;
    assign d_done             = (state_q == S_RESP) && owner_q;
    assign i_rdata            = i_rdata_q;
    assign d_rdata            = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level timing model (grant cycle g -> bus busy g+1..g+L, done at
// g+L+1, arbiter free again at g+L+2) and a word-array model of memory.
module tb_mem_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_clr = 1'b1;

    logic        a_req  [2];
    logic        a_we   [2];
    logic [31:0] a_addr [2];
    logic [31:0] a_wd   [2];

    logic [31:0] i_rdata, d_rdata, mem_address_output, mem_data_in, mem_data_out;
    logic        i_done, d_done, mem_write_en, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(L), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(a_req[0]), .i_write_en(a_we[0]), .i_address(a_addr[0]), .i_wdata(a_wd[0]),
        .i_rdata(i_rdata), .i_done(i_done),
        .d_req(a_req[1]), .d_write_en(a_we[1]), .d_address(a_addr[1]), .d_wdata(a_wd[1]),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_address_output(mem_address_output), .mem_write_en(mem_write_en),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    // Preload contents of the memory; word 0x100 holds 0xDEADBEEF.
    function automatic logic [31:0] initv(input logic [8:0] idx);
        if (idx == 9'h100) return 32'hDEADBEEF;
        return {23'b0, idx} * 32'h9E3779B1 + 32'h13579BDF;
    endfunction

    // Bench memory: combinational read, write on posedge while enabled.
    logic [31:0] bmem    [512];
    logic        wr_flag [512];
    assign mem_data_out = wr_flag[mem_address_output[8:0]] ? bmem[mem_address_output[8:0]]
                                                           : initv(mem_address_output[8:0]);
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 512; k++) wr_flag[k] <= 1'b0;
        end else if (mem_write_en) begin
            bmem[mem_address_output[8:0]]    <= mem_data_in;
            wr_flag[mem_address_output[8:0]] <= 1'b1;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [512];
    logic [31:0] exp_rdata [2];
    logic [31:0] exp_addr, exp_wd, maddr, mwd;
    bit          active, owner, mwe, rr_last, capture;
    int          cyc, g, idle_at, txn;
    int          checks, errors;
    bit          dut_order [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int p);
        a_req[p]  = 1'b1;
        a_we[p]   = ($urandom_range(0, 2) == 0);
        a_addr[p] = 32'($urandom_range(0, 511));
        a_wd[p]   = $urandom;
    endtask

    task automatic set_req(input int p, input bit we, input logic [31:0] ad, input logic [31:0] wd);
        a_req[p] = 1'b1; a_we[p] = we; a_addr[p] = ad; a_wd[p] = wd;
    endtask

    // Reset asserted at the current negedge; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b1;
        a_req[0] = 1'b0; a_req[1] = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_i_done", i_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_mem_we", mem_write_en, 0);
        chk("rst_mem_addr", mem_address_output, 0);
        chk("rst_mem_din", mem_data_in, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        active = 0; idle_at = 0; rr_last = 0;
        exp_addr = 0; exp_wd = 0; exp_rdata[0] = 0; exp_rdata[1] = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle. mode 0: owner drops req at done; 1: random traffic;
    // 2: requesters keep req high (immediate new request with same fields).
    task automatic step(input int mode);
        bit in_acc, in_resp, win;
        // Arbitration for the cycle ending at the coming posedge.
        if (!active && cyc >= idle_at && (a_req[0] || a_req[1])) begin
            if (a_req[0] && a_req[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                win = 1'b1;
`else
                win = ~rr_last;
`endif
            end else begin
                win = a_req[1];
            end
            rr_last = win; owner = win; g = cyc; active = 1;
            mwe = a_we[win]; maddr = a_addr[win]; mwd = a_wd[win];
            exp_addr = maddr; exp_wd = mwd;
        end
        @(negedge clk);
        cyc++;
        in_acc  = active && (cyc > g) && (cyc <= g + L);
        in_resp = active && (cyc == g + L + 1);
        if (in_resp && !mwe) exp_rdata[owner] = ref_mem[maddr[8:0]];
        chk("busy", busy, in_acc || in_resp);
        chk("mem_we", mem_write_en, in_acc && mwe);
        chk("mem_addr", mem_address_output, exp_addr);
        chk("mem_din", mem_data_in, exp_wd);
        chk("i_done", i_done, in_resp && !owner);
        chk("d_done", d_done, in_resp && owner);
        chk("i_rdata", i_rdata, exp_rdata[0]);
        chk("d_rdata", d_rdata, exp_rdata[1]);
        if (capture && i_done) dut_order.push_back(1'b0);
        if (capture && d_done) dut_order.push_back(1'b1);
        if (in_resp) begin
            txn++;
            $display("txn %0d port=%s we=%0d addr=%h data=%h done@%0d", txn,
                     owner ? "D" : "I", mwe, maddr, mwe ? mwd : ref_mem[maddr[8:0]], cyc);
            if (mwe) ref_mem[maddr[8:0]] = mwd;
            active = 0; idle_at = cyc + 1;
            if (mode != 2) begin
                a_req[owner] = 1'b0;
                if (mode == 1 && $urandom_range(0, 1) == 1) new_req(int'(owner));
            end
        end
        if (mode == 1) begin
            // Granted requester may change its inputs; the bus must not follow.
            if (in_acc) begin
                a_addr[owner] = $urandom;
                a_wd[owner]   = $urandom;
                a_we[owner]   = $urandom_range(0, 1) == 1;
            end
            for (int p = 0; p < 2; p++) begin
                if (!a_req[p] && $urandom_range(0, 3) == 0) new_req(p);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; txn = 0; capture = 0;
        for (int p = 0; p < 2; p++) begin
            a_req[p] = 0; a_we[p] = 0; a_addr[p] = 0; a_wd[p] = 0;
        end
        for (int k = 0; k < 512; k++) ref_mem[k] = initv(9'(k));

        @(negedge clk);
        do_reset();
        mem_clr = 1'b0;

        // D read of preloaded word 0x100
        set_req(1, 1'b0, 32'h100, 32'h0);
        repeat (L + 3) step(0);
        chk("t1_d_rdata", d_rdata, 32'hDEADBEEF);

        // D write 0x40 then readback
        set_req(1, 1'b1, 32'h40, 32'h11223344);
        repeat (L + 3) step(0);
        chk("t4_rdata_kept", d_rdata, 32'hDEADBEEF);
        set_req(1, 1'b0, 32'h40, 32'h0);
        repeat (L + 3) step(0);
        chk("t4_readback", d_rdata, 32'h11223344);

        // Reset during ACCESS cycle 2 of an I read, then a fresh I read
        set_req(0, 1'b0, 32'h7, 32'h0);
        repeat (2) step(0);
        do_reset();
        set_req(0, 1'b0, 32'h100, 32'h0);
        repeat (L + 3) step(0);
        chk("t5_i_rdata", i_rdata, 32'hDEADBEEF);

        // Both request right after reset and stay high for 4 transactions
        do_reset();
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 32'h20, 32'h0);
        capture = 1;
        repeat (4 * (L + 2)) step(2);
        capture = 0;
        a_req[0] = 1'b0; a_req[1] = 1'b0;
        repeat (L + 3) step(0);
        chk("t3_count", 32'(dut_order.size()), 4);
        for (int k = 0; k < 4 && k < dut_order.size(); k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            chk("t3_order", {31'b0, dut_order[k]}, 1);
`else
            chk("t3_order", {31'b0, dut_order[k]}, (k % 2 == 0) ? 1 : 0);
`endif
        end

        // Randomized traffic with input changes during ACCESS
        repeat (2000) step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
